// File: rtl/my_dmux_stream_pkg.sv
// Shared definitions for the buffered stream demultiplexer.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package my_dmux_pkg;

  // Words each output channel can hold before it stops accepting.
  localparam int BUF_DEPTH = 2;

  // Occupancy of one channel buffer.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } buf_cnt_e;

  // Select width for n channels; at least one bit so the port always exists.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/my_dmux_stream_skid_buf.sv
// Two-entry in-order buffer feeding one demux output channel.
// Latency: a push into an empty buffer is visible one cycle later.
// Backpressure: full blocks pushes; push+pop with one entry keeps full rate.
module my_skid_buf
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  buf_cnt_e         cnt;
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             do_pop;

  // mem[0] is always the head word; mem[1] only holds the queued second word.
  assign valid  = (cnt != CNT_EMPTY);
  assign full   = (cnt == CNT_FULL);
  assign data   = mem[0];
  assign do_pop = pop & valid;

  // Occupancy and storage update; pushes while full never arrive from the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= CNT_EMPTY;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      case (cnt)
        CNT_EMPTY: begin
          if (push) begin
            mem[0] <= push_data;
            cnt    <= CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && do_pop) begin
            mem[0] <= push_data;
          end else if (push) begin
            mem[1] <= push_data;
            cnt    <= CNT_FULL;
          end else if (do_pop) begin
            cnt    <= CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (do_pop) begin
            mem[0] <= mem[1];
            cnt    <= CNT_ONE;
          end
        end
        default: cnt <= CNT_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/my_dmux_stream.sv
// Buffered 1-to-N stream demux with broadcast and dropped-word counting.
// Latency: one cycle from input accept to output valid when the channel is empty.
// Backpressure: in_ready depends only on buffer fullness, never on out_ready.
module my_dmux_stream
  import my_dmux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_OUT = 8,
  parameter  int CNT_W = 8,
  localparam int SEL_W = sel_w(N_OUT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   err,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_OUT);

  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] push;
  logic             sel_ok;
  logic             sel_full;
  logic             in_acc;
  logic             drop_vld;

  // Selects at or above N_OUT hit no channel and are discarded.
  assign sel_ok   = ({1'b0, in_sel} < N_LIM);
  assign sel_full = |(full & hit);

  // Broadcast needs room everywhere so it lands atomically; drops always pass.
  assign in_ready = in_bcast ? ~(|full) : (sel_ok ? ~sel_full : 1'b1);
  assign in_acc   = in_valid & in_ready;
  assign push     = {N_OUT{in_acc}} & ({N_OUT{in_bcast}} | hit);
  assign drop_vld = in_acc & ~in_bcast & ~sel_ok;

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    assign hit[k] = (in_sel == SEL_W'(k));

    my_skid_buf #(
      .WIDTH (WIDTH)
    ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (push[k]),
      .push_data (in_data),
      .full      (full[k]),
      .pop       (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*WIDTH +: WIDTH])
    );
  end

  // One-cycle error pulse per dropped word and a saturating drop tally.
  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err <= drop_vld;
      if (drop_vld && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_my_dmux_stream.sv
// Bench for my_dmux_stream: 8-channel instance against a queue model,
// plus a 6-channel, 2-bit-counter instance for the drop path.
module tb_my_dmux_stream;

  logic        clk = 1'b0;
  logic        reset;

  // 8-channel instance
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic        err;
  logic [7:0]  drop_cnt;

  // 6-channel instance
  logic [7:0]  d6_data;
  logic [2:0]  d6_sel;
  logic        d6_bcast;
  logic        d6_valid;
  logic        d6_ready;
  logic [47:0] d6_out_data;
  logic [5:0]  d6_out_valid;
  logic [5:0]  d6_out_ready;
  logic        d6_err;
  logic [1:0]  d6_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;
  logic thr_en = 1'b0;
  int   thr_acc = 0;

  always #5 clk = ~clk;

  my_dmux_stream #(.WIDTH(8), .N_OUT(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .drop_cnt(drop_cnt)
  );

  my_dmux_stream #(.WIDTH(8), .N_OUT(6), .CNT_W(2)) u_dut6 (
    .clk(clk), .reset(reset), .in_data(d6_data), .in_sel(d6_sel),
    .in_bcast(d6_bcast), .in_valid(d6_valid), .in_ready(d6_ready),
    .out_data(d6_out_data), .out_valid(d6_out_valid), .out_ready(d6_out_ready),
    .err(d6_err), .drop_cnt(d6_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- Model of the 8-channel instance ----------------
  // Each channel is a list of words accepted but not yet consumed; a channel
  // with two pending words refuses more. The head word is what must be shown.
  logic [7:0] mq [8][$];
  int         m_drops = 0;
  logic       m_err   = 1'b0;

  function automatic logic m_rdy();
    if (in_bcast) begin
      for (int k = 0; k < 8; k++) if (mq[k].size() >= 2) return 1'b0;
      return 1'b1;
    end
    if (int'(in_sel) < 8) return (mq[in_sel].size() < 2);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic acc;
    if (reset) begin
      for (int k = 0; k < 8; k++) mq[k].delete();
      m_drops = 0;
      m_err   = 1'b0;
    end else begin
      acc = in_valid && m_rdy();
      if (thr_en && in_valid && in_ready) thr_acc++;
      for (int k = 0; k < 8; k++)
        if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
      m_err = acc && !in_bcast && (int'(in_sel) >= 8);
      if (m_err && m_drops < 255) m_drops++;
      if (acc) begin
        if (in_bcast) begin
          for (int k = 0; k < 8; k++) mq[k].push_back(in_data);
        end else if (int'(in_sel) < 8) begin
          mq[in_sel].push_back(in_data);
        end
      end
    end
  end

  // Per-cycle comparison of the 8-channel instance against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(mq[k].size() != 0));
        if (mq[k].size() != 0)
          check($sformatf("out_data[%0d]", k), 64'(out_data[k*8 +: 8]), 64'(mq[k][0]));
      end
      if (in_valid) check("in_ready", 64'(in_ready), 64'(m_rdy()));
      check("err", 64'(err), 64'(m_err));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    end
  end

  initial begin
    reset = 1'b1;
    in_data = 8'hEE; in_sel = 3'd3; in_bcast = 1'b0; in_valid = 1'b1; out_ready = 8'hFF;
    d6_data = 8'hEE; d6_sel = 3'd1; d6_bcast = 1'b0; d6_valid = 1'b1; d6_out_ready = 6'h3F;

    // 1: reset held 3 cycles while words are offered
    step();
    chk_en = 1'b1;
    step();
    step();
    check("rst out_valid", 64'(out_valid), 64'h0);
    check("rst out_data", out_data, 64'h0);
    check("rst err", 64'(err), 64'h0);
    check("rst drop_cnt", 64'(drop_cnt), 64'h0);
    check("rst d6 out_valid", 64'(d6_out_valid), 64'h0);
    check("rst d6 drop_cnt", 64'(d6_cnt), 64'h0);
    reset = 1'b0; in_valid = 1'b0; d6_valid = 1'b0;
    step();
    check("post-rst out_valid", 64'(out_valid), 64'h0);
    step();
    check("post-rst d6 out_valid", 64'(d6_out_valid), 64'h0);

    // 2: unicast, including both select boundaries
    in_data = 8'hA5; in_sel = 3'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("uni out_valid", 64'(out_valid), 64'h08);
    check("uni data3", 64'(out_data[31:24]), 64'hA5);
    step();
    check("uni drained", 64'(out_valid), 64'h00);
    in_data = 8'h3C; in_sel = 3'd0; in_valid = 1'b1;
    step();
    in_data = 8'hC3; in_sel = 3'd7;
    check("uni0 out_valid", 64'(out_valid), 64'h01);
    check("uni0 data", 64'(out_data[7:0]), 64'h3C);
    step();
    in_valid = 1'b0;
    check("uni7 out_valid", 64'(out_valid), 64'h80);
    check("uni7 data", 64'(out_data[63:56]), 64'hC3);
    step();

    // 3: backpressure on channel 2, channel 5 unaffected
    out_ready[2] = 1'b0;
    in_data = 8'h11; in_sel = 3'd2; in_valid = 1'b1;
    step();
    in_data = 8'h22;
    step();
    in_data = 8'h33;
    #1 check("bp in_ready full", 64'(in_ready), 64'h0);
    step();
    in_data = 8'h55; in_sel = 3'd5;
    #1 check("bp in_ready other", 64'(in_ready), 64'h1);
    step();
    check("bp ch5 valid", 64'(out_valid[5]), 64'h1);
    check("bp ch5 data", 64'(out_data[47:40]), 64'h55);
    check("bp ch2 head", 64'(out_data[23:16]), 64'h11);
    in_data = 8'h33; in_sel = 3'd2; out_ready[2] = 1'b1;
    step();
    check("bp ch2 second", 64'(out_data[23:16]), 64'h22);
    step();
    in_valid = 1'b0;
    check("bp ch2 third", 64'(out_data[23:16]), 64'h33);
    step();
    check("bp drained", 64'(out_valid), 64'h00);

    // 4: broadcast blocked by a full channel, then atomic delivery
    out_ready[6] = 1'b0;
    in_data = 8'h61; in_sel = 3'd6; in_valid = 1'b1;
    step();
    in_data = 8'h62;
    step();
    in_data = 8'h7E; in_bcast = 1'b1;
    #1 check("bc in_ready blocked", 64'(in_ready), 64'h0);
    step();
    step();
    check("bc nothing written", 64'(out_valid), 64'h40);
    out_ready[6] = 1'b1;
    step();
    step();
    in_valid = 1'b0; in_bcast = 1'b0;
    check("bc all valid", 64'(out_valid), 64'hFF);
    check("bc all data", out_data, 64'h7E7E7E7E7E7E7E7E);
    step();
    check("bc drained", 64'(out_valid), 64'h00);

    // 5: drops on the 6-channel instance, counter saturates at 3
    d6_sel = 3'd7; d6_data = 8'h99; d6_valid = 1'b1;
    #1 check("d6 in_ready drop", 64'(d6_ready), 64'h1);
    step();
    d6_valid = 1'b0;
    check("d6 err pulse", 64'(d6_err), 64'h1);
    check("d6 cnt 1", 64'(d6_cnt), 64'h1);
    check("d6 no output", 64'(d6_out_valid), 64'h0);
    step();
    check("d6 err cleared", 64'(d6_err), 64'h0);
    check("d6 cnt held", 64'(d6_cnt), 64'h1);
    d6_sel = 3'd6; d6_valid = 1'b1;
    repeat (4) step();
    d6_valid = 1'b0;
    check("d6 cnt sat", 64'(d6_cnt), 64'h3);
    step();
    check("d6 err end", 64'(d6_err), 64'h0);
    check("d6 cnt stuck", 64'(d6_cnt), 64'h3);
    d6_sel = 3'd5; d6_data = 8'h5C; d6_valid = 1'b1;
    step();
    d6_valid = 1'b0;
    check("d6 ch5 valid", 64'(d6_out_valid), 64'h20);
    check("d6 ch5 data", 64'(d6_out_data[47:40]), 64'h5C);
    step();

    // 6: random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_bcast  = ($urandom_range(0, 7) == 0);
      in_data   = 8'($urandom);
      out_ready = 8'($urandom) | 8'($urandom);
      step();
    end

    // Full-rate phase: every offered word must be taken
    out_ready = 8'hFF;
    in_valid = 1'b0;
    step();
    step();
    thr_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      in_sel   = 3'($urandom_range(0, 7));
      in_bcast = ($urandom_range(0, 7) == 0);
      in_data  = 8'($urandom);
      step();
    end
    thr_en = 1'b0;
    in_valid = 1'b0;
    check("throughput", 64'(thr_acc), 64'd200);
    step();
    step();
    check("final drained", 64'(out_valid), 64'h00);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
